// File: rtl/ip4_rtl_sp_pipe_if.sv
// Operand/result handshake bundle for the SIMD stream-processor lane array.
// master = operand fetch / writeback side, slave = lane array.
interface ip4_rtl_sp_pipe_if #(
    parameter int unsigned NUM_SP = 8,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned TAG_W  = 6
);
    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 in_op;
    logic [NUM_SP-1:0]          in_mask;
    logic [TAG_W-1:0]           in_tag;
    logic [NUM_SP*WORD_W-1:0]   in_op0;
    logic [NUM_SP*WORD_W-1:0]   in_op1;
    logic [NUM_SP*WORD_W-1:0]   in_op2;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_SP*WORD_W-1:0]   out_res;
    logic [NUM_SP-1:0]          out_cy;
    logic [NUM_SP-1:0]          out_zero;
    logic [NUM_SP-1:0]          out_mask;
    logic [TAG_W-1:0]           out_tag;
    logic                       out_err;
    logic                       busy;

    modport master (
        output in_valid, in_op, in_mask, in_tag, in_op0, in_op1, in_op2, out_ready,
        input  in_ready, out_valid, out_res, out_cy, out_zero, out_mask, out_tag, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_mask, in_tag, in_op0, in_op1, in_op2, out_ready,
        output in_ready, out_valid, out_res, out_cy, out_zero, out_mask, out_tag, out_err, busy
    );
endinterface

// File: rtl/ip4_rtl_sp_pipe.sv
// SIMD integer lane array: NUM_SP lanes share one opcode, results flow through an
// elastic valid/ready pipeline of STAGES register stages (latency = STAGES).
module ip4_rtl_sp_pipe #(
    parameter int unsigned NUM_SP  = 8,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned HAS_MUL = 1,
    parameter int unsigned TAG_W   = 6
) (
    input logic              clk,
    input logic              rst_n,
    ip4_rtl_sp_pipe_if.slave bus
);
    localparam int unsigned LANES_W = NUM_SP * WORD_W;
    localparam int unsigned SH_W    = $clog2(WORD_W);

    typedef enum logic [3:0] {
        OpNop, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr,
        OpSra, OpSlt, OpSltu, OpMul, OpMax, OpMin, OpMad, OpIll
    } op_e;

    // Returns {carry/borrow, result}; carry bit is only meaningful for ADD/SUB.
    function automatic logic [WORD_W:0] alu(op_e fop, logic [WORD_W-1:0] a,
                                             logic [WORD_W-1:0] b, logic [WORD_W-1:0] c);
        logic [WORD_W:0]   r;
        logic [SH_W-1:0]   sh;
        r  = '0;
        sh = b[SH_W-1:0];
        case (fop)
            OpNop:   r[WORD_W-1:0] = a;
            OpAdd:   r = {1'b0, a} + {1'b0, b};
            OpSub:   begin
                r[WORD_W-1:0] = a - b;
                r[WORD_W]     = (a < b);
            end
            OpAnd:   r[WORD_W-1:0] = a & b;
            OpOr:    r[WORD_W-1:0] = a | b;
            OpXor:   r[WORD_W-1:0] = a ^ b;
            OpShl:   r[WORD_W-1:0] = a << sh;
            OpShr:   r[WORD_W-1:0] = a >> sh;
            OpSra:   r[WORD_W-1:0] = WORD_W'($signed(a) >>> sh);
            OpSlt:   r[0] = ($signed(a) < $signed(b));
            OpSltu:  r[0] = (a < b);
            OpMul:   r[WORD_W-1:0] = a * b;
            OpMax:   r[WORD_W-1:0] = ($signed(a) > $signed(b)) ? a : b;
            OpMin:   r[WORD_W-1:0] = ($signed(a) < $signed(b)) ? a : b;
            OpMad:   r[WORD_W-1:0] = a * b + c;
            default: r = '0;
        endcase
        return r;
    endfunction

    op_e                 op;
    logic [WORD_W:0]     lane;
    logic [LANES_W-1:0]  comp_res;
    logic [NUM_SP-1:0]   comp_cy;
    logic [NUM_SP-1:0]   comp_zero;
    logic                comp_err;

    assign op = op_e'(bus.in_op);

    always_comb begin
        comp_err  = (op == OpIll) || ((HAS_MUL == 0) && ((op == OpMul) || (op == OpMad)));
        comp_res  = '0;
        comp_cy   = '0;
        comp_zero = '0;
        lane      = '0;
        for (int i = 0; i < NUM_SP; i++) begin
            if (bus.in_mask[i] && !comp_err) begin
                lane = alu(op, bus.in_op0[i*WORD_W +: WORD_W], bus.in_op1[i*WORD_W +: WORD_W],
                           bus.in_op2[i*WORD_W +: WORD_W]);
                comp_res[i*WORD_W +: WORD_W] = lane[WORD_W-1:0];
                comp_cy[i]                   = lane[WORD_W];
                comp_zero[i]                 = (lane[WORD_W-1:0] == '0);
            end
        end
    end

    logic [STAGES-1:0]   v_q;
    logic [STAGES-1:0]   v_d;
    logic [STAGES-1:0]   rdy;
    logic [STAGES-1:0]   ld;
    logic [LANES_W-1:0]  res_q  [STAGES];
    logic [NUM_SP-1:0]   cy_q   [STAGES];
    logic [NUM_SP-1:0]   zero_q [STAGES];
    logic [NUM_SP-1:0]   mask_q [STAGES];
    logic [TAG_W-1:0]    tag_q  [STAGES];
    logic [STAGES-1:0]   err_q;

    // A stage can take a new beat if it or any later stage holds a bubble, or the
    // output drains this cycle; computed per stage to keep the chain flat.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = bus.out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!v_q[j]) rdy[k] = 1'b1;
            end
        end
        ld     = '0;
        v_d    = v_q;
        ld[0]  = rdy[0] && bus.in_valid;
        if (rdy[0]) v_d[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = rdy[k] && v_q[k-1];
            if (rdy[k]) v_d[k] = v_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            err_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k]  <= '0;
                cy_q[k]   <= '0;
                zero_q[k] <= '0;
                mask_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            v_q <= v_d;
            if (ld[0]) begin
                res_q[0]  <= comp_res;
                cy_q[0]   <= comp_cy;
                zero_q[0] <= comp_zero;
                mask_q[0] <= bus.in_mask;
                tag_q[0]  <= bus.in_tag;
                err_q[0]  <= comp_err;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    res_q[k]  <= res_q[k-1];
                    cy_q[k]   <= cy_q[k-1];
                    zero_q[k] <= zero_q[k-1];
                    mask_q[k] <= mask_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                    err_q[k]  <= err_q[k-1];
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_res   = res_q[STAGES-1];
    assign bus.out_cy    = cy_q[STAGES-1];
    assign bus.out_zero  = zero_q[STAGES-1];
    assign bus.out_mask  = mask_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
    assign bus.out_err   = err_q[STAGES-1];
    assign bus.busy      = |v_q;
endmodule

// File: tb/tb_ip4_rtl_sp_pipe.sv
// Directed bench for ip4_rtl_sp_pipe: opcode vectors, masking, HAS_MUL=0 build,
// randomised backpressure stream against a scoreboard, and mid-flight reset.
module tb_ip4_rtl_sp_pipe;
    localparam int unsigned STAGES = 2;
    typedef logic [286:0] beat_t;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    ip4_rtl_sp_pipe_if #(.NUM_SP(8), .WORD_W(32), .TAG_W(6)) bus1 ();
    ip4_rtl_sp_pipe_if #(.NUM_SP(8), .WORD_W(32), .TAG_W(6)) bus2 ();

    ip4_rtl_sp_pipe #(.NUM_SP(8), .WORD_W(32), .STAGES(STAGES), .HAS_MUL(1), .TAG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    ip4_rtl_sp_pipe #(.NUM_SP(8), .WORD_W(32), .STAGES(STAGES), .HAS_MUL(0), .TAG_W(6)) dut_nomul (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.in_op     = bus1.in_op;
    assign bus2.in_mask   = bus1.in_mask;
    assign bus2.in_tag    = bus1.in_tag;
    assign bus2.in_op0    = bus1.in_op0;
    assign bus2.in_op1    = bus1.in_op1;
    assign bus2.in_op2    = bus1.in_op2;
    assign bus2.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the beat is on the output.
    task automatic run_beat(input logic [3:0] op, input logic [7:0] mask, input logic [5:0] tag,
                            input logic [255:0] a, input logic [255:0] b, input logic [255:0] c);
        bus1.in_valid  = 1'b1;
        bus1.in_op     = op;
        bus1.in_mask   = mask;
        bus1.in_tag    = tag;
        bus1.in_op0    = a;
        bus1.in_op1    = b;
        bus1.in_op2    = c;
        bus1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("latency_mid", bus1.out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_out", bus1.out_valid, 1'b1);
    endtask

    function automatic beat_t model(input logic [3:0] op, input logic [7:0] mask,
                                    input logic [5:0] tag, input logic [255:0] a,
                                    input logic [255:0] b);
        logic [255:0] res;
        logic [7:0]   cy;
        logic [7:0]   zero;
        logic [31:0]  x;
        logic [31:0]  y;
        logic [32:0]  s;
        res  = '0;
        cy   = '0;
        zero = '0;
        for (int i = 0; i < 8; i++) begin
            x = a[i*32 +: 32];
            y = b[i*32 +: 32];
            if (mask[i]) begin
                if (op == 4'd1) begin
                    s = {1'b0, x} + {1'b0, y};
                end else if (op == 4'd2) begin
                    s = {(x < y), x - y};
                end else begin
                    s = {1'b0, x ^ y};
                end
                res[i*32 +: 32] = s[31:0];
                cy[i]           = s[32];
                zero[i]         = (s[31:0] == 32'h0);
            end
        end
        return {res, cy, zero, mask, tag, 1'b0};
    endfunction

    logic [255:0] va, vb, vc;
    logic [255:0] exp_res;
    beat_t        q[$];
    beat_t        held;
    beat_t        obs;
    beat_t        exp_beat;
    logic         held_v;
    logic [3:0]   sop;
    int           sent, got, cyc;

    initial begin
        rst_n         = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.in_op    = '0;
        bus1.in_mask  = '0;
        bus1.in_tag   = '0;
        bus1.in_op0   = '0;
        bus1.in_op1   = '0;
        bus1.in_op2   = '0;
        bus1.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus1.out_valid, 1'b0);
        chk("rst_busy", bus1.busy, 1'b0);
        chk("rst_out_res", bus1.out_res, '0);
        chk("rst_flags", {bus1.out_cy, bus1.out_zero, bus1.out_mask, bus1.out_tag, bus1.out_err},
            '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus1.in_ready, 1'b1);

        // ADD: carry-out and wrap to zero on lane 0, plain add on lane 1
        va = '0; vb = '0; vc = '0;
        va[31:0] = 32'hFFFF_FFFF; vb[31:0] = 32'h1;
        va[63:32] = 32'h2;        vb[63:32] = 32'h3;
        run_beat(4'd1, 8'hFF, 6'h15, va, vb, vc);
        exp_res = '0; exp_res[63:32] = 32'h5;
        chk("add_res", bus1.out_res, exp_res);
        chk("add_cy", bus1.out_cy, 8'h01);
        chk("add_zero", bus1.out_zero, 8'hFD);
        chk("add_tag_err", {bus1.out_tag, bus1.out_mask, bus1.out_err}, {6'h15, 8'hFF, 1'b0});

        va = '0; vb = '0; va[31:0] = 32'h3; vb[31:0] = 32'h5;
        run_beat(4'd2, 8'hFF, 6'h01, va, vb, vc);
        chk("sub_res", bus1.out_res[31:0], 32'hFFFF_FFFE);
        chk("sub_cy_zero", {bus1.out_cy, bus1.out_zero}, {8'h01, 8'hFE});

        va = '0; vb = '0; va[31:0] = 32'h8000_0000; vb[31:0] = 32'h21;
        run_beat(4'd8, 8'hFF, 6'h02, va, vb, vc);
        chk("sra_res", bus1.out_res[31:0], 32'hC000_0000);

        va = '0; vb = '0; va[31:0] = 32'hFFFF_FFFF;
        run_beat(4'd9, 8'hFF, 6'h03, va, vb, vc);
        chk("slt_res", bus1.out_res[31:0], 32'h1);
        run_beat(4'd10, 8'hFF, 6'h04, va, vb, vc);
        chk("sltu_res", bus1.out_res[31:0], 32'h0);
        chk("sltu_zero", bus1.out_zero[0], 1'b1);

        va = '0; vb = '0; vc = '0; va[31:0] = 32'h3; vb[31:0] = 32'h4; vc[31:0] = 32'h5;
        run_beat(4'd14, 8'hFF, 6'h05, va, vb, vc);
        chk("mad_res", bus1.out_res[31:0], 32'h11);
        chk("mad_err", bus1.out_err, 1'b0);
        chk("nomul_mad_err", {bus2.out_valid, bus2.out_err}, 2'b11);
        chk("nomul_mad_res", bus2.out_res, '0);

        run_beat(4'd11, 8'hFF, 6'h06, va, vb, vc);
        chk("mul_res", bus1.out_res[31:0], 32'hC);
        chk("nomul_mul_err", bus2.out_err, 1'b1);
        chk("nomul_mul_flags", {bus2.out_res, bus2.out_cy, bus2.out_zero}, '0);

        run_beat(4'd15, 8'hFF, 6'h07, va, vb, vc);
        chk("ill_err", bus1.out_err, 1'b1);
        chk("ill_res_flags", {bus1.out_res, bus1.out_cy, bus1.out_zero}, '0);
        chk("ill_tag", bus1.out_tag, 6'h07);

        // Masked lanes 1,3,4,6 must read zero with zero flag clear
        va = '0; vb = '0; vc = '0;
        for (int i = 0; i < 8; i++) begin
            va[i*32 +: 32] = 32'(i + 1);
            vb[i*32 +: 32] = 32'd10;
        end
        run_beat(4'd1, 8'hA5, 6'h2A, va, vb, vc);
        chk("mask_res", bus1.out_res,
            {32'h12, 32'h0, 32'h10, 32'h0, 32'h0, 32'h0D, 32'h0, 32'h0B});
        chk("mask_flags", {bus1.out_cy, bus1.out_zero}, 16'h0000);
        chk("mask_echo", {bus1.out_mask, bus1.out_tag}, {8'hA5, 6'h2A});

        // Random stream with 50% output backpressure
        @(negedge clk);
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (got < 100 && cyc < 3000) begin
            obs = {bus1.out_res, bus1.out_cy, bus1.out_zero, bus1.out_mask, bus1.out_tag,
                   bus1.out_err};
            if (held_v) chk("stall_hold", {bus1.out_valid, obs}, {1'b1, held});
            bus1.out_ready = 1'($urandom_range(0, 1));
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       sop = 4'd1;
                    1:       sop = 4'd2;
                    default: sop = 4'd5;
                endcase
                for (int i = 0; i < 8; i++) begin
                    va[i*32 +: 32] = $urandom;
                    vb[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? va[i*32 +: 32] : $urandom;
                end
                bus1.in_valid = 1'b1;
                bus1.in_op    = sop;
                bus1.in_mask  = 8'($urandom);
                bus1.in_tag   = 6'(sent);
                bus1.in_op0   = va;
                bus1.in_op1   = vb;
            end else begin
                bus1.in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", bus1.in_ready, (q.size() < STAGES) || bus1.out_ready);
            if (bus1.out_valid && bus1.out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_extra_beat", 1'b1, 1'b0);
                end else begin
                    exp_beat = q.pop_front();
                    chk("stream_beat", obs, exp_beat);
                end
                got++;
            end
            held_v = bus1.out_valid && !bus1.out_ready;
            held   = obs;
            if (bus1.in_valid && bus1.in_ready) begin
                q.push_back(model(bus1.in_op, bus1.in_mask, bus1.in_tag, bus1.in_op0,
                                  bus1.in_op1));
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("stream_count", got, 100);
        chk("stream_drained", q.size(), 0);

        // Back-to-back: one beat per cycle with out_ready held high
        bus1.out_ready = 1'b1;
        bus1.in_op     = 4'd1;
        bus1.in_mask   = 8'hFF;
        for (int t = 0; t < 12; t++) begin
            bus1.in_valid = (t < 10);
            bus1.in_tag   = 6'(t);
            #1;
            chk("b2b_in_ready", bus1.in_ready, 1'b1);
            if (t >= 2) begin
                chk("b2b_out_valid", bus1.out_valid, 1'b1);
                chk("b2b_order", bus1.out_tag, 6'(t - 2));
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);

        // Fill both stages, then reset with two beats in flight
        bus1.out_ready = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_tag    = 6'h3C;
        @(posedge clk);
        @(negedge clk);
        bus1.in_tag = 6'h3D;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("full_state", {bus1.busy, bus1.out_valid, bus1.in_ready}, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {bus1.out_valid, bus1.busy}, 2'b00);
        chk("async_rst_data", {bus1.out_res, bus1.out_tag, bus1.out_mask}, '0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus1.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("no_stale_beat", bus1.out_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
